hdc_best_match: RTL and testbench

Best-match selector directly downstream of the 128-bit Hamming distance counter. It consumes one 8-bit distance per cycle for a stream of candidate descriptors belonging to one query descriptor. It tracks the smallest and second-smallest distance and the index of the best candidate. When the query closes, it emits one registered match result with an accept/reject decision.

---
 rtl/hdc_best_match.sv | 161 ++++++++++++++++
 tb/tb_hdc_best_match.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hdc_best_match.sv
// hdc_best_match: best-match selector for one query's stream of candidate
// Hamming distances. It tracks the best distance, its index and (optionally)
// the second-best distance. When the query closes it emits one registered
// result pulse carrying an accept/reject decision.
//
// Optional feature macro: HDC_RATIO_TEST_EN
//   defined   -> track the second-best distance and require the Lowe ratio
//                4*best < 3*second for acceptance
//   undefined -> no second-best tracking, second_dist is constant 8'hFF
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no query open; the next valid candidate becomes index 0
// ST_SCAN   | query open; candidates update the running best/second/index
module hdc_best_match #(
  parameter int IDX_W       = 10,
  parameter int DIST_THRESH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cand_valid,
  input  logic [7:0]       distance,
  input  logic             cand_last,
  output logic             match_valid,
  output logic [IDX_W-1:0] best_idx,
  output logic [7:0]       best_dist,
  output logic [7:0]       second_dist,
  output logic             match_ok,
  output logic             match_ovf
);

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  localparam logic [IDX_W-1:0] IDX_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [8:0]       THRESH_C = 9'(DIST_THRESH);

  state_e           state_q;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic [7:0]       run_best_q, run_best_d;

  logic             match_valid_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [7:0]       best_dist_q;
  logic             match_ok_q, match_ok_d;
  logic             match_ovf_q, match_ovf_d;
  logic             close_d;
  logic             thresh_ok;

`ifdef HDC_RATIO_TEST_EN
  logic [7:0]       run_second_q, run_second_d;
  logic [7:0]       second_dist_q;
  logic [9:0]       best_x4, second_x3;
`endif

  // Running-state update for the candidate presented this cycle
  always_comb begin
    cur_idx_d  = '0;
    run_idx_d  = run_idx_q;
    run_best_d = run_best_q;
`ifdef HDC_RATIO_TEST_EN
    run_second_d = run_second_q;
`endif
    if (state_q == ST_IDLE) begin
      cur_idx_d  = '0;
      run_idx_d  = '0;
      run_best_d = distance;
`ifdef HDC_RATIO_TEST_EN
      run_second_d = 8'hFF;
`endif
    end else begin
      cur_idx_d = cur_idx_q + IDX_ONE;
      // strict compare: an equal distance never displaces the earlier best
      if (distance < run_best_q) begin
        run_best_d = distance;
        run_idx_d  = cur_idx_d;
`ifdef HDC_RATIO_TEST_EN
        run_second_d = run_best_q;
`endif
      end
`ifdef HDC_RATIO_TEST_EN
      else if (distance < run_second_q) begin
        run_second_d = distance;
      end
`endif
    end
  end

  // Close detection and accept decision on the post-update values
  always_comb begin
    close_d     = cand_last || (cur_idx_d == IDX_MAX);
    match_ovf_d = !cand_last && (cur_idx_d == IDX_MAX);
    thresh_ok   = ({1'b0, run_best_d} <= THRESH_C);
`ifdef HDC_RATIO_TEST_EN
    best_x4    = {run_best_d, 2'b00};
    second_x3  = {2'b00, run_second_d} + {1'b0, run_second_d, 1'b0};
    match_ok_d = thresh_ok && (best_x4 < second_x3);
`else
    match_ok_d = thresh_ok;
`endif
  end

  // Query FSM, running state and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_idx_q     <= '0;
      run_idx_q     <= '0;
      run_best_q    <= 8'hFF;
      match_valid_q <= 1'b0;
      best_idx_q    <= '0;
      best_dist_q   <= 8'h00;
      match_ok_q    <= 1'b0;
      match_ovf_q   <= 1'b0;
`ifdef HDC_RATIO_TEST_EN
      run_second_q  <= 8'hFF;
      second_dist_q <= 8'hFF;
`endif
    end else begin
      match_valid_q <= 1'b0;
      if (cand_valid) begin
        if (close_d) begin
          match_valid_q <= 1'b1;
          best_idx_q    <= run_idx_d;
          best_dist_q   <= run_best_d;
          match_ok_q    <= match_ok_d;
          match_ovf_q   <= match_ovf_d;
          state_q       <= ST_IDLE;
          cur_idx_q     <= '0;
          run_idx_q     <= '0;
          run_best_q    <= 8'hFF;
`ifdef HDC_RATIO_TEST_EN
          second_dist_q <= run_second_d;
          run_second_q  <= 8'hFF;
`endif
        end else begin
          state_q    <= ST_SCAN;
          cur_idx_q  <= cur_idx_d;
          run_idx_q  <= run_idx_d;
          run_best_q <= run_best_d;
`ifdef HDC_RATIO_TEST_EN
          run_second_q <= run_second_d;
`endif
        end
      end
    end
  end

  assign match_valid = match_valid_q;
  assign best_idx    = best_idx_q;
  assign best_dist   = best_dist_q;
  assign match_ok    = match_ok_q;
  assign match_ovf   = match_ovf_q;
`ifdef HDC_RATIO_TEST_EN
  assign second_dist = second_dist_q;
`else
  assign second_dist = 8'hFF;
`endif

endmodule

// File: tb/tb_hdc_best_match.sv
// Directed bench for hdc_best_match: a default instance (IDX_W=10) and a
// narrow instance (IDX_W=3) share one stimulus stream.
module tb_hdc_best_match;

`ifdef HDC_RATIO_TEST_EN
  localparam bit RATIO = 1'b1;
`else
  localparam bit RATIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cand_valid;
  logic [7:0] distance;
  logic       cand_last;

  logic       mv, ok, ovf;
  logic [9:0] bi;
  logic [7:0] bd, sd;
  logic       mv3, ok3, ovf3;
  logic [2:0] bi3;
  logic [7:0] bd3, sd3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hdc_best_match #(.IDX_W(10), .DIST_THRESH(64)) u_dut (
    .clk(clk), .rst(rst), .cand_valid(cand_valid), .distance(distance),
    .cand_last(cand_last), .match_valid(mv), .best_idx(bi), .best_dist(bd),
    .second_dist(sd), .match_ok(ok), .match_ovf(ovf)
  );

  hdc_best_match #(.IDX_W(3), .DIST_THRESH(64)) u_dut3 (
    .clk(clk), .rst(rst), .cand_valid(cand_valid), .distance(distance),
    .cand_last(cand_last), .match_valid(mv3), .best_idx(bi3), .best_dist(bd3),
    .second_dist(sd3), .match_ok(ok3), .match_ovf(ovf3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // apply one cycle of input, then sample 1 time unit after the edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic l);
    cand_valid = v;
    distance   = d;
    cand_last  = l;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] esec(input logic [7:0] s);
    return RATIO ? s : 8'hFF;
  endfunction

  task automatic check_result(input string tag, input logic [9:0] idx,
                              input logic [7:0] b, input logic [7:0] s,
                              input logic k, input logic o);
    check({tag, ".valid"},  32'(mv),  32'd1);
    check({tag, ".idx"},    32'(bi),  32'(idx));
    check({tag, ".best"},   32'(bd),  32'(b));
    check({tag, ".second"}, 32'(sd),  32'(s));
    check({tag, ".ok"},     32'(ok),  32'(k));
    check({tag, ".ovf"},    32'(ovf), 32'(o));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"},  32'(mv),  32'd0);
    check({tag, ".idx"},    32'(bi),  32'd0);
    check({tag, ".best"},   32'(bd),  32'd0);
    check({tag, ".second"}, 32'(sd),  32'hFF);
    check({tag, ".ok"},     32'(ok),  32'd0);
    check({tag, ".ovf"},    32'(ovf), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cand_valid = 1'b0;
    distance = 8'd0;
    cand_last = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset("reset");
    check("reset.w3_valid", 32'(mv3), 32'd0);
    rst = 1'b0;
    cyc(0, 0, 0);

    // 40,12,30,12(last): tie keeps idx 1, tie lowers second to 12
    cyc(1, 40, 0);
    cyc(1, 12, 0);
    cyc(1, 30, 0);
    check("q1.no_early_pulse", 32'(mv), 32'd0);
    cyc(1, 12, 1);
    check_result("q1", 10'd1, 8'd12, esec(8'd12), RATIO ? 1'b0 : 1'b1, 1'b0);

    // single candidate
    cyc(1, 20, 1);
    check_result("single", 10'd0, 8'd20, 8'hFF, 1'b1, 1'b0);
    cyc(0, 0, 0);
    check("single.pulse_end", 32'(mv), 32'd0);
    check("single.hold", 32'(bd), 32'd20);

    // threshold boundary
    cyc(1, 64, 1);
    check("thr64.ok", 32'(ok), 32'd1);
    cyc(1, 65, 1);
    check("thr65.ok", 32'(ok), 32'd0);

    // back-to-back queries
    cyc(1, 70, 0);
    cyc(1, 65, 1);
    check_result("b2bA", 10'd1, 8'd65, esec(8'd70), 1'b0, 1'b0);
    cyc(1, 5, 0);
    check("b2b.gap_low", 32'(mv), 32'd0);
    cyc(1, 50, 1);
    check_result("b2bB", 10'd0, 8'd5, esec(8'd50), 1'b1, 1'b0);

    // gaps inside a query
    cyc(1, 30, 0);
    cyc(0, 0, 0);
    check("gap.idle1", 32'(mv), 32'd0);
    cyc(0, 0, 1);
    check("gap.idle_last_ignored", 32'(mv), 32'd0);
    cyc(1, 10, 1);
    check_result("gap", 10'd1, 8'd10, esec(8'd30), 1'b1, 1'b0);

    // forced close on IDX_W=3 instance after 8 candidates
    cyc(1, 90, 0);
    cyc(1, 80, 0);
    cyc(1, 70, 0);
    cyc(1, 60, 0);
    cyc(1, 50, 0);
    cyc(1, 45, 0);
    cyc(1, 44, 0);
    check("ovf.w3_not_yet", 32'(mv3), 32'd0);
    cyc(1, 43, 0);
    check("ovf.w3_valid",  32'(mv3),  32'd1);
    check("ovf.w3_ovf",    32'(ovf3), 32'd1);
    check("ovf.w3_idx",    32'(bi3),  32'd7);
    check("ovf.w3_best",   32'(bd3),  32'd43);
    check("ovf.w3_second", 32'(sd3),  32'(esec(8'd44)));
    check("ovf.w3_ok",     32'(ok3),  RATIO ? 32'd0 : 32'd1);
    check("ovf.w10_open",  32'(mv),   32'd0);
    cyc(1, 7, 1);
    check("ovf.w3_new_valid", 32'(mv3),  32'd1);
    check("ovf.w3_new_idx",   32'(bi3),  32'd0);
    check("ovf.w3_new_ovf",   32'(ovf3), 32'd0);
    check("ovf.w3_new_sec",   32'(sd3),  32'hFF);
    check_result("ovf.w10", 10'd8, 8'd7, esec(8'd43), 1'b1, 1'b0);

    // reset on the 3rd candidate of a query
    cyc(1, 10, 0);
    cyc(1, 20, 0);
    rst = 1'b1;
    cyc(1, 5, 0);
    check_reset("midrst");
    rst = 1'b0;
    cyc(0, 0, 0);
    check("midrst.no_pulse", 32'(mv), 32'd0);
    cyc(1, 33, 0);
    cyc(1, 22, 1);
    check_result("postrst", 10'd1, 8'd22, esec(8'd33), 1'b1, 1'b0);
    cyc(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
